// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types and width helpers for the systolic array edge feeders
package systolic_pkg;
  localparam int DW_DEF = 16;
  typedef enum logic [1:0] {IDLE, STREAM, DONE} feeder_state_e;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/feeder_lane.sv
// feeder_lane: one lane's operand buffer, word index and FIFO issue logic
module feeder_lane import systolic_pkg::*; #(
  parameter int LANES = 4,
  parameter int DEPTH = 16,
  parameter int DW = DW_DEF,
  parameter int ID = 0,
  localparam int LW = idx_w(LANES),
  localparam int AW = idx_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          clear,
  input  logic          run,
  input  logic [LW-1:0] skew,
  input  logic [AW:0]   len,
  input  logic          ff,
  output logic          we,
  output logic [DW-1:0] dout,
  output logic          fin
);
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0] idx;
  logic eligible;
  assign eligible = run && skew >= LW'(ID);
  assign we = eligible && idx < len && !ff;
  assign dout = eligible ? mem[idx[AW-1:0]] : '0;
  // finished once this cycle's issue (if any) brings idx up to len
  assign fin = idx + (AW+1)'(we) == len;
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) idx <= '0;
    else if (clear) idx <= '0;
    else if (we) idx <= idx + 1'b1;
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers per-lane operand vectors and streams them into PE FIFOs
// with a one-cycle-per-lane diagonal skew, honouring per-lane back-pressure.
module systolic_feeder import systolic_pkg::*; #(
  parameter int LANES = 4,
  parameter int DEPTH = 16,
  parameter int DW = DW_DEF,
  localparam int LW = idx_w(LANES),
  localparam int AW = idx_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [LW-1:0]     wr_lane,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic [AW:0]       len,
  input  logic              go,
  input  logic [LANES-1:0]  ff,
  output logic [LANES-1:0]  we,
  output logic [LANES*DW-1:0] dout,
  output logic              is_out,
  output logic              start,
  output logic [7:0]        max_cntr,
  output logic              busy,
  output logic              done
);
  feeder_state_e state, nxt;
  logic [LW-1:0] skew;
  logic [AW:0] len_q;
  logic [LANES-1:0] fin;
  logic s0, accept, run;
  assign accept = state == IDLE && go && len != '0 && len <= (AW+1)'(DEPTH);
  assign run = state == STREAM;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE ? (accept ? STREAM : IDLE) :
          state == STREAM ? (&fin ? DONE : STREAM) : IDLE;
  always_comb begin
    is_out = state == IDLE;
    busy = state != IDLE;
    done = state == DONE;
    start = s0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s0 <= 1'b0;
      len_q <= '0;
      max_cntr <= '0;
      skew <= '0;
    end else begin
      s0 <= accept;
      if (accept) begin
        len_q <= len;
        max_cntr <= 8'(len - 1'b1);
        skew <= '0;
      end else if (run && skew != LW'(LANES-1)) skew <= skew + 1'b1;
    end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    feeder_lane #(.LANES(LANES), .DEPTH(DEPTH), .DW(DW), .ID(i)) u_lane (
      .clk(clk),
      .rst_n(rst_n),
      .wr_en(wr_en && state == IDLE && wr_lane == LW'(i)),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .clear(accept),
      .run(run),
      .skew(skew),
      .len(len_q),
      .ff(ff[i]),
      .we(we[i]),
      .dout(dout[i*DW +: DW]),
      .fin(fin[i])
    );
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: scoreboard bench for systolic_feeder (LANES=4, DEPTH=16, DW=16)
module tb_systolic_feeder;
  localparam int L = 4, D = 16, W = 16;
  logic clk = 0, rst_n = 0, wr_en = 0, go = 0;
  logic [1:0] wr_lane = 0;
  logic [3:0] wr_addr = 0;
  logic [W-1:0] wr_data = 0;
  logic [4:0] len = 0;
  logic [L-1:0] ff = 0;
  logic [L-1:0] we;
  logic [L*W-1:0] dout;
  logic is_out, start, busy, done;
  logic [7:0] max_cntr;
  int tests = 0, fails = 0;
  logic [W-1:0] mdl [L][D];
  typedef struct {int cyc; logic [W-1:0] d;} exp_t;
  exp_t sb [L][$];

  systolic_feeder #(.LANES(L), .DEPTH(D), .DW(W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_lane(wr_lane), .wr_addr(wr_addr),
    .wr_data(wr_data), .len(len), .go(go), .ff(ff), .we(we), .dout(dout),
    .is_out(is_out), .start(start), .max_cntr(max_cntr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input int l, input int a, input logic [W-1:0] d);
    @(posedge clk) #1;
    wr_en = 1; wr_lane = 2'(l); wr_addr = 4'(a); wr_data = d; mdl[l][a] = d;
    @(posedge clk) #1 wr_en = 0;
  endtask

  task automatic load();
    for (int i = 0; i < L; i++)
      for (int j = 0; j < D; j++) wr(i, j, W'(16*i + j));
  endtask

  task automatic flush();
    for (int i = 0; i < L; i++) sb[i].delete();
  endtask

  task automatic run(input int n, input logic [L-1:0] ffm, input int f0, input int f1,
                     input int inj, input int rst_at, input bit wrgo, input logic [W-1:0] wv);
    int last, c;
    exp_t e;
    last = 0;
    if (wrgo) mdl[0][0] = wv;
    for (int i = 0; i < L; i++) begin
      c = i;
      for (int j = 0; j < n; j++) begin
        while (ffm[i] && c >= f0 && c <= f1) c++;
        sb[i].push_back('{c, mdl[i][j]});
        c++;
      end
      if (c > last) last = c;
    end
    @(posedge clk) #1;
    len = 5'(n); go = 1;
    if (wrgo) begin wr_en = 1; wr_lane = 0; wr_addr = 0; wr_data = wv; end
    @(posedge clk) #1;
    go = 0; wr_en = 0;
    for (int k = 0; k < n + 40; k++) begin
      ff = (k >= f0 && k <= f1) ? ffm : '0;
      if (k == inj) begin go = 1; len = 5'd3; wr_en = 1; wr_lane = 2; wr_addr = 0; wr_data = 16'hAAAA; end
      @(negedge clk);
      if (k == 0) begin
        check("start", start, 1);
        check("max_cntr", max_cntr, 32'(n - 1));
        check("is_out_stream", is_out, 0);
        check("busy_stream", busy, 1);
      end else if (k == 1) check("start_low", start, 0);
      for (int i = 0; i < L; i++) begin
        if (ff[i] && k >= i && sb[i].size() > 0) begin
          check($sformatf("held_we%0d", i), we[i], 0);
          check($sformatf("held_dout%0d", i), dout[i*W +: W], sb[i][0].d);
        end
        if (we[i]) begin
          if (sb[i].size() == 0) check($sformatf("extra_we%0d", i), 1, 0);
          else begin
            e = sb[i].pop_front();
            check($sformatf("cyc%0d", i), k, e.cyc);
            check($sformatf("data%0d", i), dout[i*W +: W], e.d);
          end
        end
      end
      if (k == rst_at) begin
        #1 rst_n = 0;
        #1;
        check("rst_we", we, 0);
        check("rst_is_out", is_out, 1);
        check("rst_busy", busy, 0);
        flush();
        @(posedge clk) #1;
        rst_n = 1; ff = 0; go = 0; wr_en = 0;
        return;
      end
      if (done) begin
        check("done_cyc", k, last);
        check("busy_in_done", busy, 1);
        for (int i = 0; i < L; i++) check($sformatf("left%0d", i), sb[i].size(), 0);
        @(posedge clk) #1;
        ff = 0; go = 0; wr_en = 0;
        check("done_pulse", done, 0);
        check("busy_after", busy, 0);
        check("is_out_idle", is_out, 1);
        return;
      end
      @(posedge clk) #1;
      go = 0; wr_en = 0;
    end
    check("timeout", 1, 0);
    flush();
    ff = 0;
  endtask

  task automatic bad_go(input logic [4:0] n);
    @(posedge clk) #1;
    len = n; go = 1;
    @(posedge clk) #1 go = 0;
    repeat (2) begin
      @(negedge clk);
      check($sformatf("bad_len%0d_busy", n), busy, 0);
      check($sformatf("bad_len%0d_is", n), is_out, 1);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_we0", we, 0);
    check("rst_dout0", dout[31:0], 0);
    check("rst_is0", is_out, 1);
    check("rst_start0", start, 0);
    check("rst_max0", max_cntr, 0);
    check("rst_busy0", busy, 0);
    check("rst_done0", done, 0);
    rst_n = 1;
    load();
    run(3, 4'b0000, 0, -1, -1, -1, 0, 0);
    run(3, 4'b0010, 1, 3, -1, -1, 0, 0);
    bad_go(5'd0);
    bad_go(5'd17);
    run(16, 4'b0000, 0, -1, -1, -1, 0, 0);
    run(3, 4'b0000, 0, -1, 2, -1, 0, 0);
    run(1, 4'b0000, 0, -1, -1, -1, 0, 0);
    run(3, 4'b0000, 0, -1, -1, 2, 0, 0);
    load();
    run(3, 4'b0000, 0, -1, -1, -1, 0, 0);
    run(2, 4'b0000, 0, -1, -1, -1, 1, 16'hFFFB);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got 0 exp 1");
    $fatal(1, "watchdog");
  end
endmodule
